// File: rtl/model_state_matrix_vector_product.sv
// -----------------------------------------------------------------------------
// model_state_matrix_vector_product
//
// Streams a row-major signed matrix A (SIZE_I x SIZE_J) paired element-by-
// element with a signed vector B (length SIZE_J) and emits one signed dot
// product per row. Each accepted pair adds its full-width product to a
// double-width wrapping accumulator. The row result is strobed one cycle
// after the row's last pair, and the next row may be fed in that same cycle.
//
// Optional feature (macro MODEL_STATE_SATURATION_EN):
//   defined   -> row result clamps the accumulator to the signed DATA_SIZE range
//   undefined -> row result is the low DATA_SIZE bits of the accumulator (wrap)
//
// Ports:
//   CLK             in   clock, rising edge
//   RST             in   asynchronous active-low reset
//   START           in   one-cycle request to begin a product (IDLE only)
//   SIZE_I_IN       in   number of matrix rows
//   SIZE_J_IN       in   number of matrix columns / vector length
//   DATA_IN_ENABLE  in   DATA_A_IN / DATA_B_IN pair valid this cycle
//   DATA_A_IN       in   signed matrix element
//   DATA_B_IN       in   signed vector element
//   DATA_OUT        out  signed row result (holds between strobes)
//   DATA_OUT_ENABLE out  one-cycle strobe marking DATA_OUT valid
//   INDEX_OUT       out  row index of DATA_OUT (holds between strobes)
//   READY           out  one-cycle strobe marking product complete
// -----------------------------------------------------------------------------
module model_state_matrix_vector_product #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic                    DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_ENABLE,
  output logic [CONTROL_SIZE-1:0] INDEX_OUT,
  output logic                    READY
);

  localparam int ACC_SIZE = 2 * DATA_SIZE;

  typedef enum logic {IDLE, ACCUMULATE} state_t;

  state_t                  state, state_next;
  logic [CONTROL_SIZE-1:0] size_i, size_i_d;
  logic [CONTROL_SIZE-1:0] size_j, size_j_d;
  logic [CONTROL_SIZE-1:0] row_cnt, row_cnt_d;
  logic [CONTROL_SIZE-1:0] col_cnt, col_cnt_d;
  logic [ACC_SIZE-1:0]     acc, acc_d;
  logic [DATA_SIZE-1:0]    data_out_d;
  logic [CONTROL_SIZE-1:0] index_out_d;
  logic                    data_out_enable_d;
  logic                    ready_d;

  logic [ACC_SIZE-1:0]     a_ext, b_ext, product, sum;
  logic [DATA_SIZE-1:0]    converted;
  logic                    accept, last_col, last_row, size_zero;

  // Sign-extending both operands first makes the low ACC_SIZE bits of an
  // unsigned multiply equal to the exact signed product.
  assign a_ext   = {{DATA_SIZE{DATA_A_IN[DATA_SIZE-1]}}, DATA_A_IN};
  assign b_ext   = {{DATA_SIZE{DATA_B_IN[DATA_SIZE-1]}}, DATA_B_IN};
  assign product = a_ext * b_ext;
  assign sum     = acc + product;

  assign accept    = (state == ACCUMULATE) && DATA_IN_ENABLE;
  assign last_col  = (col_cnt == size_j - CONTROL_SIZE'(1));
  assign last_row  = (row_cnt == size_i - CONTROL_SIZE'(1));
  assign size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0);

`ifdef MODEL_STATE_SATURATION_EN
  // The sum fits the narrow range when its top DATA_SIZE+1 bits all match
  // the sign; otherwise clamp toward the sign of the wide value.
  always_comb begin
    converted = sum[DATA_SIZE-1:0];
    if (!((&sum[ACC_SIZE-1:DATA_SIZE-1]) || !(|sum[ACC_SIZE-1:DATA_SIZE-1]))) begin
      converted = sum[ACC_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                  : {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
  end
`else
  assign converted = sum[DATA_SIZE-1:0];
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (START && !size_zero) state_next = ACCUMULATE;
      ACCUMULATE: if (accept && last_col && last_row) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    size_i_d          = size_i;
    size_j_d          = size_j;
    row_cnt_d         = row_cnt;
    col_cnt_d         = col_cnt;
    acc_d             = acc;
    data_out_d        = DATA_OUT;
    index_out_d       = INDEX_OUT;
    data_out_enable_d = 1'b0;
    ready_d           = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          if (size_zero) begin
            ready_d = 1'b1;
          end else begin
            size_i_d  = SIZE_I_IN;
            size_j_d  = SIZE_J_IN;
            row_cnt_d = '0;
            col_cnt_d = '0;
            acc_d     = '0;
          end
        end
      end
      ACCUMULATE: begin
        if (accept) begin
          if (last_col) begin
            // Row complete: publish and restart the accumulator on the same
            // edge so the next row's first pair can arrive in the strobe cycle.
            data_out_d        = converted;
            index_out_d       = row_cnt;
            data_out_enable_d = 1'b1;
            ready_d           = last_row;
            col_cnt_d         = '0;
            acc_d             = '0;
            row_cnt_d         = row_cnt + CONTROL_SIZE'(1);
          end else begin
            col_cnt_d = col_cnt + CONTROL_SIZE'(1);
            acc_d     = sum;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_i          <= '0;
      size_j          <= '0;
      row_cnt         <= '0;
      col_cnt         <= '0;
      acc             <= '0;
      DATA_OUT        <= '0;
      INDEX_OUT       <= '0;
      DATA_OUT_ENABLE <= 1'b0;
      READY           <= 1'b0;
    end else begin
      size_i          <= size_i_d;
      size_j          <= size_j_d;
      row_cnt         <= row_cnt_d;
      col_cnt         <= col_cnt_d;
      acc             <= acc_d;
      DATA_OUT        <= data_out_d;
      INDEX_OUT       <= index_out_d;
      DATA_OUT_ENABLE <= data_out_enable_d;
      READY           <= ready_d;
    end
  end

endmodule
